// File: rtl/gene_trajectory_gen.sv
// gene_trajectory_gen -- Boolean gene-network trajectory source.
//
// Loads an 8-gene state, applies next[i] = x[i-1] | (x[i] & x[i+1]) once per
// accepted transfer and streams x[t] over a valid/ready handshake. Attractors
// are detected against the last HIST states. The result is a period in 1..HIST,
// or 0 when the step count reaches MAX_STEPS.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, init       launch request and initial state (sampled in IDLE)
//   x_ready           downstream accepts x this cycle
//   x_valid, x        current state x[t] stream
//   busy              trajectory / sweep in progress
//   done, last        end-of-trajectory pulse; last marks the final one
//   period, steps     attractor period (0 = timeout) and transfer index t
//   init_cur          initial state of the current/last trajectory
//
// Optional feature: define GENE_SWEEP_EN to make start run every initial state
// 0 .. 2^N-1 back to back instead of a single trajectory from init.

module gene_cell (
  input  logic left,
  input  logic self_b,
  input  logic right,
  output logic nxt
);
  assign nxt = left | (self_b & right);
endmodule

module gene_trajectory_gen #(
  parameter int N         = 8,
  parameter int HIST      = 4,
  parameter int MAX_STEPS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] init,
  input  logic         x_ready,
  output logic         x_valid,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         last,
  output logic [2:0]   period,
  output logic [7:0]   steps,
  output logic [N-1:0] init_cur
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_e;

  state_e                 state_q, state_d;
  logic [N-1:0]           x_q, x_d;
  logic [7:0]             t_q, t_d;
  logic [N-1:0]           init_cur_q, init_cur_d;
  logic [2:0]             period_q, period_d;
  logic [7:0]             steps_q, steps_d;
  logic [HIST-1:0][N-1:0] hist_q, hist_d;
  logic [HIST-1:0]        hist_vld_q, hist_vld_d;

  logic [N-1:0]    x_nxt;
  logic [HIST-1:0] hit;
  logic            match_any;
  logic [2:0]      match_k;

  // One update cell per gene; neighbours wrap around the ring.
  for (genvar i = 0; i < N; i++) begin : g_cell
    gene_cell u_cell (
      .left   (x_q[(i + N - 1) % N]),
      .self_b (x_q[i]),
      .right  (x_q[(i + 1) % N]),
      .nxt    (x_nxt[i])
    );
  end

  // hist_q[k] holds x[t-(k+1)]; unfilled entries never match.
  for (genvar k = 0; k < HIST; k++) begin : g_hit
    assign hit[k] = hist_vld_q[k] && (hist_q[k] == x_q);
  end

  // Scan from the oldest entry down so the smallest distance wins.
  always_comb begin
    match_any = 1'b0;
    match_k   = '0;
    for (int k = HIST - 1; k >= 0; k--) begin
      if (hit[k]) begin
        match_any = 1'b1;
        match_k   = 3'(k + 1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    t_d        = t_q;
    init_cur_d = init_cur_q;
    period_d   = period_q;
    steps_d    = steps_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef GENE_SWEEP_EN
          x_d        = '0;
          init_cur_d = '0;
`else
          x_d        = init;
          init_cur_d = init;
`endif
          t_d        = '0;
          hist_vld_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (x_ready) begin
          if (match_any) begin
            period_d = match_k;
            steps_d  = t_q;
            state_d  = REPORT;
          end else if (t_q == 8'(MAX_STEPS)) begin
            period_d = '0;
            steps_d  = t_q;
            state_d  = REPORT;
          end else begin
            hist_d[0]     = x_q;
            hist_vld_d[0] = 1'b1;
            for (int k = 1; k < HIST; k++) begin
              hist_d[k]     = hist_q[k-1];
              hist_vld_d[k] = hist_vld_q[k-1];
            end
            x_d = x_nxt;
            t_d = t_q + 8'd1;
          end
        end
      end
      REPORT: begin
`ifdef GENE_SWEEP_EN
        // Chain straight into the next initial state without an IDLE cycle.
        if (&init_cur_q) begin
          state_d = IDLE;
        end else begin
          init_cur_d = init_cur_q + 1'b1;
          x_d        = init_cur_q + 1'b1;
          t_d        = '0;
          hist_vld_d = '0;
          state_d    = RUN;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      t_q        <= '0;
      init_cur_q <= '0;
      period_q   <= '0;
      steps_q    <= '0;
      hist_q     <= '0;
      hist_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      t_q        <= t_d;
      init_cur_q <= init_cur_d;
      period_q   <= period_d;
      steps_q    <= steps_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end

  assign x_valid  = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == REPORT);
`ifdef GENE_SWEEP_EN
  assign last     = done & (&init_cur_q);
`else
  assign last     = done;
`endif
  assign x        = x_q;
  assign period   = period_q;
  assign steps    = steps_q;
  assign init_cur = init_cur_q;

endmodule

// File: tb/tb_gene_trajectory_gen.sv
module tb_gene_trajectory_gen;
  localparam int N = 8, HIST = 4, MAX_STEPS = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, x_ready;
  logic [N-1:0] init;
  logic         x_valid, busy, done, last;
  logic [N-1:0] x, init_cur;
  logic [2:0]   period;
  logic [7:0]   steps;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];

  gene_trajectory_gen #(.N(N), .HIST(HIST), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init), .x_ready(x_ready),
    .x_valid(x_valid), .x(x), .busy(busy), .done(done), .last(last),
    .period(period), .steps(steps), .init_cur(init_cur)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] f_next(input logic [N-1:0] s);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = s[(i + N - 1) % N] | (s[i] & s[(i + 1) % N]);
    return r;
  endfunction

  // Reference trajectory: pushes the expected x stream, returns the result.
  task automatic model(input logic [N-1:0] iv, output logic [2:0] mp, output logic [7:0] ms);
    logic [N-1:0] s[$];
    bit found;
    s.push_back(iv);
    mp = 0; ms = 0;
    for (int t = 0; t <= MAX_STEPS; t++) begin
      found = 0;
      for (int k = 1; k <= HIST; k++)
        if (!found && t >= k && s[t-k] == s[t]) begin
          found = 1; mp = 3'(k); ms = 8'(t);
        end
      exp_q.push_back(s[t]);
      if (found) break;
      if (t == MAX_STEPS) begin mp = 0; ms = 8'(t); break; end
      s.push_back(f_next(s[t]));
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; init = 0; x_ready = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({x_valid, busy, done, last, x, period, steps, init_cur} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b b=%b d=%b l=%b x=%h p=%0d s=%0d ic=%h, want all zero",
               x_valid, busy, done, last, x, period, steps, init_cur);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

`ifndef GENE_SWEEP_EN
  // One trajectory; toggle=1 gives x_ready pattern 1,0,0,1,0,0,...
  task automatic run_traj(input string name, input logic [N-1:0] iv, input bit toggle,
                          input logic [2:0] ep, input logic [7:0] es);
    logic [2:0] mp; logic [7:0] ms;
    bit got_done = 0;
    exp_q.delete();
    model(iv, mp, ms);
    start = 1; init = iv; x_ready = 0;
    @(negedge clk);
    start = 0;
    n_checks++;
    if (x_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL %s first_valid: got v=%b b=%b, want 1 1", name, x_valid, busy);
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done === 1'b1) begin
        got_done = 1;
        n_checks++;
        if (period !== ep || steps !== es) begin
          n_fail++; $display("FAIL %s result: got p=%0d s=%0d, want p=%0d s=%0d", name, period, steps, ep, es);
        end
        n_checks++;
        if (last !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b1 || init_cur !== iv) begin
          n_fail++; $display("FAIL %s done_flags: got l=%b v=%b b=%b ic=%h, want 1 0 1 %h", name, last, x_valid, busy, init_cur, iv);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++; $display("FAIL %s stream_len: got %0d unconsumed, want 0", name, exp_q.size());
        end
        // start coincident with done must be ignored
        start = 1; init = 8'h0F; x_ready = 0;
        @(negedge clk);
        start = 0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s after_done: got b=%b d=%b v=%b, want 0 0 0", name, busy, done, x_valid);
        end
        break;
      end
      // a start mid-run must be ignored
      start = (cyc == 2);
      init  = ~iv;
      x_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      n_checks++;
      if (x_valid !== 1'b1 || busy !== 1'b1 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s run_flags: got v=%b b=%b q=%0d, want 1 1 >0", name, x_valid, busy, exp_q.size());
      end else begin
        n_checks++;
        if (x !== exp_q[0]) begin
          n_fail++; $display("FAIL %s x_stream: got %h, want %h (ready=%b)", name, x, exp_q[0], x_ready);
        end
        if (x_ready) void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    start = 0; x_ready = 0;
    if (!got_done) begin
      n_checks++; n_fail++; $display("FAIL %s timeout: got no done, want done", name);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] mp; logic [7:0] ms;
    exp_q.delete();
    start = 1; init = 8'h03; x_ready = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);    // three transfers: t = 3
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({x_valid, busy, done, last, x, period, steps, init_cur} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b b=%b d=%b l=%b x=%h p=%0d s=%0d ic=%h, want all zero",
               x_valid, busy, done, last, x, period, steps, init_cur);
    end
    x_ready = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_traj("after_reset_ff", 8'hFF, 0, 3'd1, 8'd1);
  endtask
`else
  task automatic test_sweep();
    logic [2:0] mp; logic [7:0] ms;
    int idx = 0;
    bit fin = 0;
    exp_q.delete();
    model(8'h00, mp, ms);
    start = 1; init = 8'hA5; x_ready = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (done === 1'b1) begin
        n_checks++;
        if (init_cur !== 8'(idx) || period !== mp || steps !== ms || x_valid !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep_done: got ic=%h p=%0d s=%0d v=%b b=%b, want ic=%h p=%0d s=%0d v=0 b=1",
                   init_cur, period, steps, x_valid, busy, 8'(idx), mp, ms);
        end
        n_checks++;
        if (last !== (idx == 255)) begin
          n_fail++; $display("FAIL sweep_last: got %b at init %h, want %b", last, 8'(idx), idx == 255);
        end
        if (idx == 255) begin
          n_checks++;
          if (period !== 3'd1) begin
            n_fail++; $display("FAIL sweep_final_period: got %0d, want 1", period);
          end
          fin = 1;
          break;
        end
        idx++;
        exp_q.delete();
        model(8'(idx), mp, ms);
      end else begin
        n_checks++;
        if (x_valid !== 1'b1 || exp_q.size() == 0 || x !== exp_q[0]) begin
          n_fail++; $display("FAIL sweep_stream: got v=%b x=%h at init %h, want v=1 x=expected", x_valid, x, 8'(idx));
        end else void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    if (!fin) begin
      n_checks++; n_fail++; $display("FAIL sweep_timeout: got %0d done pulses, want 256", idx);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_busy_end: got %b, want 0", busy);
    end
    x_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef GENE_SWEEP_EN
    run_traj("fixed_03", 8'h03, 0, 3'd1, 8'd7);
    run_traj("period2_55", 8'h55, 0, 3'd2, 8'd2);
    run_traj("timeout_01", 8'h01, 0, 3'd0, 8'd16);
    run_traj("backpressure_55", 8'h55, 1, 3'd2, 8'd2);
    run_traj("back_to_back_03", 8'h03, 0, 3'd1, 8'd7);
    test_reset_mid();
`else
    test_sweep();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end
endmodule

// File: doc/gene_trajectory_gen.md
# gene_trajectory_gen

Gene-network trajectory generator: the producing end of the gene-state stream. It loads an initial 8-gene state, iterates the fixed Boolean update rule once per accepted transfer, and streams x[t] to downstream cycle/attractor checkers over a valid/ready handshake. It also detects attractors itself against a short history window and reports the period and the step count. It sits between the stimulus/sweep controller and the cycle-checking blocks.

## Interface
- N, 8, number of genes (state width)
- HIST, 4, history depth; detectable attractor periods 1..HIST (HIST ≤ 7)
- MAX_STEPS, 16, transfer index at which a trajectory times out (≤ 255)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  launch request, sampled only in IDLE
- init  in  N  initial gene state, sampled with start
- x_ready  in  1  downstream accepts x this cycle
- x_valid  out  1  x holds a valid state x[t]
- x  out  N  current gene state x[t]
- busy  out  1  trajectory (or sweep) in progress
- done  out  1  one-cycle pulse: trajectory finished, results valid
- last  out  1  with done: final trajectory of the run
- period  out  3  attractor period 1..HIST; 0 = timeout
- steps  out  8  transfer index t at which the match or timeout occurred
- init_cur  out  N  initial state of the current/last trajectory

## Operation
- Update rule, indices mod N: next[i] = x[i-1] | (x[i] & x[i+1]).
- States: IDLE, RUN, REPORT.
- IDLE: start=1 → latch init into x and init_cur, t=0, clear history valid bits → RUN. start outside IDLE is ignored.
- RUN: x_valid=1. On handshake (x_valid & x_ready):
  - compare x with history entries H1..HIST (H1 = x[t-1]); the smallest matching distance k → period=k, steps=t → REPORT.
  - else if t == MAX_STEPS → period=0, steps=t → REPORT.
  - else shift x into H1 (oldest entry dropped), x ← next(x), t ← t+1.
- No handshake: x, t and the history hold; x stays stable while x_valid & !x_ready.
- REPORT: done=1 for one cycle, last=1 (single mode) → IDLE. period/steps/init_cur hold until the next launch.
- Only history entries that hold valid data participate in the compare; entries not yet filled never match.
- Reset (any time, including mid-trajectory): FSM=IDLE; x_valid, busy, done, last = 0; x, period, steps, init_cur, t, history = 0.

## Timing
- start at edge k → x_valid=1 with x=init from cycle k+1.
- With x_ready held at 1: one state per cycle. The final handshake is at edge j, and done is high in cycle j+1.
- busy is high from cycle k+1 through the done cycle inclusive.
- x_valid is 0 in the REPORT and IDLE cycles.
- A start coincident with done is ignored. The earliest relaunch is the cycle after done.

## Configuration
- GENE_SWEEP_EN defined: start ignores init and runs init = 0 .. 2^N-1 in order.
  - After each REPORT, the FSM loads the next init directly into RUN with no IDLE cycle; x_valid returns the cycle after done.
  - done pulses once per trajectory. last=1 only with the done of init = 2^N-1.
  - busy stays high from launch until that final done.
- GENE_SWEEP_EN undefined: single trajectory per start. last is asserted with every done.

## Test plan
- init=8'h03, x_ready=1: x stream 03,07,0F,1F,3F,7F,FF,FF; done with period=1, steps=7.
- init=8'h55, x_ready=1: x stream 55,AA,55; done with period=2, steps=2.
- init=8'h01, x_ready=1 (period-8 rotation, exceeds HIST): 17 transfers 01,02,04,…; done with period=0, steps=16.
- init=8'h55 with x_ready toggling 1,0,0,1,…: x holds stable while not ready. The stream and result are identical to the x_ready=1 case.
- rst_n pulsed low mid-trajectory (t=3): all outputs zero immediately. A subsequent start with init=8'hFF gives x stream FF,FF and period=1, steps=1.
- With GENE_SWEEP_EN, x_ready=1: 256 done pulses with init_cur 00..FF in order. last=1 only on the final one, with period=1 (init FF). busy falls after the final done.
